bcd_display_driver: RTL and testbench

- Downstream consumer of the up/down counter's n-bit count output.
- Converts the binary count to packed BCD using a sequential shift-add-3 (double-dabble) engine with a load/busy/valid handshake.
- Drives a time-multiplexed common seven-segment display from the latched BCD digits.

---
 rtl/bcd_display_driver_if.sv | 22 ++
 rtl/bcd_display_driver.sv | 142 ++++++++++++++
 tb/tb_bcd_display_driver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_driver_if.sv
// Handshake bundle between a value producer and bcd_display_driver:
// conversion request (value/load) and result (busy/bcd/bcd_valid).
interface bcd_display_driver_if #(
  parameter int N      = 5,
  parameter int DIGITS = 2
);
  logic [N-1:0]        value;
  logic                load;
  logic                busy;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;

  modport master (
    output value, load,
    input  busy, bcd, bcd_valid
  );

  modport slave (
    input  value, load,
    output busy, bcd, bcd_valid
  );
endinterface

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter driving a multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_display_driver #(
  parameter int N        = 5,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_display_driver_if.slave   bus,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    shreg;
  logic [BW-1:0]   scratch, adj, bcd_q;
  logic [CW-1:0]   cnt;
  logic            valid_q;

  logic [SW-1:0]   scnt;
  logic [IW-1:0]   idx;
  logic [3:0]      cur_nib;
  logic            blank;
  logic [DIGITS-1:0] an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(N - 1)) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adj = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      else                           adj[4*d +: 4] = scratch[4*d +: 4];
    end
  end

  // Digits beyond DIGITS fall off the top of scratch, leaving value mod 10^DIGITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.load) begin
          shreg   <= bus.value;
          scratch <= '0;
          cnt     <= '0;
        end
        SHIFT: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          cnt              <= cnt + 1'b1;
        end
        LATCH: begin
          bcd_q   <= scratch;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = valid_q;

  // Blanking looks at the current digit and all digits above it in the latched result.
  always_comb begin
    cur_nib = '0;
    an_nxt  = '0;
    blank   = (idx != '0);
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (IW'(d) == idx) begin
        cur_nib   = bcd_q[4*d +: 4];
        an_nxt[d] = 1'b1;
      end
      if (IW'(d) >= idx && bcd_q[4*d +: 4] != 4'd0) blank = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
      idx  <= '0;
      an   <= '0;
      seg  <= '0;
    end else begin
      if (scnt == SW'(SCAN_DIV - 1)) begin
        scnt <= '0;
        idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        scnt <= scnt + 1'b1;
      end
      an <= an_nxt;
`ifdef LEADING_ZERO_BLANK_EN
      seg <= blank ? 7'h00 : decode(cur_nib);
`else
      seg <= decode(cur_nib);
`endif
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed testbench for bcd_display_driver (N=5, DIGITS=2, SCAN_DIV=4).
module tb_bcd_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [1:0] an;
  int         checks   = 0;
  int         failures = 0;

  bcd_display_driver_if #(.N(5), .DIGITS(2)) bus ();

  bcd_display_driver #(.N(5), .DIGITS(2), .SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .seg (seg),
    .an  (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (bus.bcd_valid) ok = 1'b1;
    end
  endtask

  // Advance until an has just switched from digit 1 to digit 0.
  task automatic wait_digit0(output bit ok);
    logic [1:0] prev;
    ok   = 1'b0;
    prev = an;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (prev == 2'b10 && an == 2'b01) ok = 1'b1;
      prev = an;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.load = 1'b0; bus.value = '0;
    tick(); tick();
    checks++; if (bus.busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.bcd !== 8'h00)      begin failures++; $display("FAIL reset_bcd got=%h exp=00", bus.bcd); end
    checks++; if (bus.bcd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.bcd_valid); end
    checks++; if (an !== 2'b00)           begin failures++; $display("FAIL reset_an got=%b exp=00", an); end
    checks++; if (seg !== 7'h00)          begin failures++; $display("FAIL reset_seg got=%h exp=00", seg); end
    rst = 1'b0;
    tick();
    checks++; if (an !== 2'b01)  begin failures++; $display("FAIL release_an got=%b exp=01", an); end
    checks++; if (seg !== 7'h3F) begin failures++; $display("FAIL release_seg got=%h exp=3f", seg); end
  endtask

  task automatic test_basic();
    int busy_cycles = 0;
    bus.value = 5'd23; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy === 1'b1 && bus.bcd_valid === 1'b0) busy_cycles++;
      if (i < 5) tick();
    end
    checks++; if (busy_cycles != 6) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=6", busy_cycles); end
    tick();
    checks++; if (bus.bcd_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.bcd_valid); end
    checks++; if (bus.busy !== 1'b0)      begin failures++; $display("FAIL basic_busy_end got=%b exp=0", bus.busy); end
    checks++; if (bus.bcd !== 8'h23)      begin failures++; $display("FAIL basic_bcd got=%h exp=23", bus.bcd); end
    tick();
    checks++; if (bus.bcd_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", bus.bcd_valid); end
  endtask

  task automatic test_load_while_busy();
    int pulses = 0;
    bus.value = 5'd31; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    bus.value = 5'd7; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.bcd_valid) pulses++;
    end
    checks++; if (pulses != 1)       begin failures++; $display("FAIL busy_load_pulses got=%0d exp=1", pulses); end
    checks++; if (bus.bcd !== 8'h31) begin failures++; $display("FAIL busy_load_bcd got=%h exp=31", bus.bcd); end
  endtask

  task automatic test_scan();
    bit ok;
    int bad = 0;
    wait_digit0(ok);
    checks++; if (!ok) begin failures++; $display("FAIL scan_sync got=timeout exp=digit0"); end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (an !== 2'b01 || seg !== 7'h06) begin
          bad++; $display("FAIL scan_d0 got an=%b seg=%h exp an=01 seg=06", an, seg);
        end
        tick();
      end
      for (int i = 0; i < 4; i++) begin
        if (an !== 2'b10 || seg !== 7'h4F) begin
          bad++; $display("FAIL scan_d1 got an=%b seg=%h exp an=10 seg=4f", an, seg);
        end
        tick();
      end
    end
    checks++; if (bad != 0) failures++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int pulses = 0;
    bus.value = 5'd19; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.bcd !== 8'h00) begin failures++; $display("FAIL midrst_bcd got=%h exp=00", bus.bcd); end
    for (int i = 0; i < 10; i++) begin
      if (bus.bcd_valid) pulses++;
      tick();
    end
    checks++; if (pulses != 0)       begin failures++; $display("FAIL midrst_valid got=%0d exp=0", pulses); end
    checks++; if (bus.bcd !== 8'h00) begin failures++; $display("FAIL midrst_bcd_hold got=%h exp=00", bus.bcd); end
    bus.value = 5'd19; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_valid(12, ok);
    checks++; if (!ok)               begin failures++; $display("FAIL midrst_reload got=timeout exp=valid"); end
    checks++; if (bus.bcd !== 8'h19) begin failures++; $display("FAIL midrst_reload_bcd got=%h exp=19", bus.bcd); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.value = 5'd30; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_valid(12, ok);
    checks++; if (!ok || bus.bcd !== 8'h30) begin failures++; $display("FAIL b2b_first got=%h exp=30", bus.bcd); end
    bus.value = 5'd12; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
    wait_valid(12, ok);
    checks++; if (!ok || bus.bcd !== 8'h12) begin failures++; $display("FAIL b2b_second got=%h exp=12", bus.bcd); end
  endtask

  task automatic test_blank();
    bit ok;
    logic [6:0] exp_d1;
`ifdef LEADING_ZERO_BLANK_EN
    exp_d1 = 7'h00;
`else
    exp_d1 = 7'h3F;
`endif
    bus.value = 5'd7; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_valid(12, ok);
    checks++; if (!ok || bus.bcd !== 8'h07) begin failures++; $display("FAIL blank_bcd got=%h exp=07", bus.bcd); end
    wait_digit0(ok);
    checks++; if (!ok || an !== 2'b01 || seg !== 7'h07) begin
      failures++; $display("FAIL blank_d0 got an=%b seg=%h exp an=01 seg=07", an, seg);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (an !== 2'b10 || seg !== exp_d1) begin
      failures++; $display("FAIL blank_d1 got an=%b seg=%h exp an=10 seg=%h", an, seg, exp_d1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_while_busy();
    test_scan();
    test_reset_mid();
    test_back_to_back();
    test_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
